// File: rtl/he_lut_remap_if.sv
// Bus bundle for he_lut_remap: table load path, pixel stream in/out and status.
interface he_lut_remap_if;
  logic        stal_i;
  logic        lut_gecerli_i;
  logic [23:0] lut_veri_i;
  logic        lut_temizle_i;
  logic        etkin_i;
  logic [7:0]  pixel_i;
  logic [7:0]  pixel_o;
  logic        gecerli_o;
  logic        atlandi_o;
  logic        lut_hazir_o;
  logic [16:0] sayac_o;

  modport slave (
    input  stal_i, lut_gecerli_i, lut_veri_i, lut_temizle_i, etkin_i, pixel_i,
    output pixel_o, gecerli_o, atlandi_o, lut_hazir_o, sayac_o
  );

  modport master (
    output stal_i, lut_gecerli_i, lut_veri_i, lut_temizle_i, etkin_i, pixel_i,
    input  pixel_o, gecerli_o, atlandi_o, lut_hazir_o, sayac_o
  );
endinterface

// File: rtl/he_lut_remap.sv
// Histogram-equalisation LUT remapper: loads a 256x8 table, then remaps a
// pixel stream through it; pixels seen before the table is complete pass
// through unchanged and are flagged as bypassed.
//
// state | meaning
// BOS   | table empty/invalidated, waiting for entry 0
// YUKLE | loading entries 1..255 at the write pointer
// HAZIR | table complete, pixels are remapped
module he_lut_remap (
  input logic          clk_i,
  input logic          rstn_i,
  he_lut_remap_if.slave bus
);
  typedef enum logic [1:0] {BOS, YUKLE, HAZIR} state_t;

  localparam logic [16:0] SAYAC_MAX = 17'h1FFFF;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  lut_q [256];
  logic        wr_en;
  logic [7:0]  wr_addr;

  logic        s1_v_q, s1_v_d;
  logic [7:0]  s1_pix_q, s1_pix_d;
  logic        s1_rdy_q, s1_rdy_d;
  logic        gec_q, gec_d;
  logic        atl_q, atl_d;
  logic [7:0]  pix_q, pix_d;
  logic [16:0] sayac_q, sayac_d;

  logic        unused_veri_hi;
  assign unused_veri_hi = ^bus.lut_veri_i[23:8];

  // Load FSM next state and table write enable; clear beats any load request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    if (!bus.stal_i) begin
      if (bus.lut_temizle_i) begin
        state_d = BOS;
        ptr_d   = '0;
      end else begin
        case (state_q)
          BOS: begin
            if (bus.lut_gecerli_i) begin
              wr_en   = 1'b1;
              ptr_d   = 8'd1;
              state_d = YUKLE;
            end
          end
          YUKLE: begin
            if (bus.lut_gecerli_i) begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 8'd1;
              if (ptr_q == 8'hFF) state_d = HAZIR;
            end
          end
          HAZIR: ;
          default: begin
            state_d = BOS;
            ptr_d   = '0;
          end
        endcase
      end
    end
  end

  // Entry 0 is written from BOS regardless of where the pointer sits.
  assign wr_addr = (state_q == BOS) ? 8'd0 : ptr_q;

  // Pixel pipeline and remap counter next state; stall freezes everything.
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_pix_d = s1_pix_q;
    s1_rdy_d = s1_rdy_q;
    gec_d    = gec_q;
    atl_d    = atl_q;
    pix_d    = pix_q;
    sayac_d  = sayac_q;
    if (!bus.stal_i) begin
      s1_v_d   = bus.etkin_i;
      s1_pix_d = bus.pixel_i;
      s1_rdy_d = (state_q == HAZIR);
      gec_d    = s1_v_q;
      atl_d    = s1_v_q & ~s1_rdy_q;
      if (s1_v_q) pix_d = s1_rdy_q ? lut_q[s1_pix_q] : s1_pix_q;
      if (bus.lut_temizle_i) sayac_d = '0;
      else if (gec_q && !atl_q && (sayac_q != SAYAC_MAX)) sayac_d = sayac_q + 17'd1;
    end
  end

  // Control, pipeline and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= BOS;
      ptr_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_pix_q <= '0;
      s1_rdy_q <= 1'b0;
      gec_q    <= 1'b0;
      atl_q    <= 1'b0;
      pix_q    <= '0;
      sayac_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      s1_v_q   <= s1_v_d;
      s1_pix_q <= s1_pix_d;
      s1_rdy_q <= s1_rdy_d;
      gec_q    <= gec_d;
      atl_q    <= atl_d;
      pix_q    <= pix_d;
      sayac_q  <= sayac_d;
    end
  end

  // Table storage; contents survive reset and clear, only reloads change them.
  always_ff @(posedge clk_i) begin
    if (wr_en) lut_q[wr_addr] <= bus.lut_veri_i[7:0];
  end

  assign bus.pixel_o     = pix_q;
  assign bus.gecerli_o   = gec_q;
  assign bus.atlandi_o   = atl_q;
  assign bus.lut_hazir_o = (state_q == HAZIR);
  assign bus.sayac_o     = sayac_q;
endmodule
